// File: rtl/regfile_wb_pipe.sv
// regfile_wb_pipe
//   Integer register file for the RISC-V core. NREAD registered read ports and
//   one write port. The write address/enable travel down a WB_DELAY-stage line
//   so the write lands in the same cycle its data arrives from writeback.
//   A committing write is forwarded to same-cycle reads, x0 always reads zero,
//   and a per-register pending-write counter drives the hazard busy flags.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-high; clears registers, delay line, counters
//   i_wr_issue     a write to i_wr_addr is issued this cycle
//   i_wr_addr      destination register of the issued write
//   i_wr_data      data for the write committing this cycle
//   i_rs_addr      read addresses, port k at [k*AW +: AW]
//   o_rd_data      registered read data, port k at [k*XLEN +: XLEN]
//   o_rs_busy      combinational: port k's register has a write in flight
//   o_commit_vld   a write commits this cycle (delay-line tail valid)
//   o_commit_addr  address committing this cycle
module regfile_wb_pipe #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int WB_DELAY = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               i_wr_issue,
  input  logic [$clog2(NREGS)-1:0]           i_wr_addr,
  input  logic [XLEN-1:0]                    i_wr_data,
  input  logic [NREAD*$clog2(NREGS)-1:0]     i_rs_addr,
  output logic [NREAD*XLEN-1:0]              o_rd_data,
  output logic [NREAD-1:0]                   o_rs_busy,
  output logic                               o_commit_vld,
  output logic [$clog2(NREGS)-1:0]           o_commit_addr
);

  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(WB_DELAY + 1);

  // Write delay line: stage 0 captures the issue, the last stage is the commit.
  logic [WB_DELAY-1:0]         r_dl_vld;
  logic [WB_DELAY-1:0][AW-1:0] r_dl_addr;

  logic [XLEN-1:0]             r_regs [NREGS];
  logic [CW-1:0]               r_cnt  [NREGS];
  logic [NREAD-1:0][XLEN-1:0]  r_rd_data;

  logic                        w_commit_en;
  logic [NREGS-1:0]            w_inc;
  logic [NREGS-1:0]            w_dec;

  assign o_commit_vld  = r_dl_vld[WB_DELAY-1];
  assign o_commit_addr = r_dl_addr[WB_DELAY-1];
  // Commits to x0 are dropped so x0 never holds anything but zero.
  assign w_commit_en   = o_commit_vld && (o_commit_addr != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_dl_vld  <= '0;
      r_dl_addr <= '0;
    end else begin
      r_dl_vld[0]  <= i_wr_issue;
      r_dl_addr[0] <= i_wr_addr;
      for (int s = 1; s < WB_DELAY; s++) begin
        r_dl_vld[s]  <= r_dl_vld[s-1];
        r_dl_addr[s] <= r_dl_addr[s-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
    end else if (w_commit_en) begin
      r_regs[o_commit_addr] <= i_wr_data;
    end
  end

  // Scoreboard decode; x0 is excluded on both sides.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (i_wr_issue && (i_wr_addr != '0)) w_inc[i_wr_addr] = 1'b1;
    if (w_commit_en)                     w_dec[o_commit_addr] = 1'b1;
  end

  // Issue and commit of the same register in one cycle cancel out.
  always_ff @(posedge clock) begin
    for (int r = 0; r < NREGS; r++) begin
      if (reset || r == 0)          r_cnt[r] <= '0;
      else if (w_inc[r] && !w_dec[r]) r_cnt[r] <= r_cnt[r] + CW'(1);
      else if (w_dec[r] && !w_inc[r]) r_cnt[r] <= r_cnt[r] - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < NREAD; k++) begin
      if (reset) begin
        r_rd_data[k] <= '0;
      end else if (i_rs_addr[k*AW +: AW] == '0) begin
        r_rd_data[k] <= '0;
      end else if (o_commit_vld && (o_commit_addr == i_rs_addr[k*AW +: AW])) begin
        // Bypass: the value being written this edge, not the stale array entry.
        r_rd_data[k] <= i_wr_data;
      end else begin
        r_rd_data[k] <= r_regs[i_rs_addr[k*AW +: AW]];
      end
    end
  end

  assign o_rd_data = r_rd_data;

  genvar gi;
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_busy
      logic [AW-1:0] w_rs_addr;
      assign w_rs_addr     = i_rs_addr[gi*AW +: AW];
      assign o_rs_busy[gi] = (r_cnt[w_rs_addr] != '0);
    end
  endgenerate

endmodule

// File: tb/tb_regfile_wb_pipe.sv
// tb_regfile_wb_pipe
//   Directed bench for regfile_wb_pipe with default parameters
//   (XLEN=32, NREGS=32, NREAD=2, WB_DELAY=2). Inputs are driven and outputs
//   sampled 1 time unit after each rising edge.
module tb_regfile_wb_pipe;

  logic        clock;
  logic        reset;
  logic        wr_issue;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rs_addr;
  logic [63:0] rd_data;
  logic [1:0]  rs_busy;
  logic        commit_vld;
  logic [4:0]  commit_addr;

  int tests = 0;
  int fails = 0;

  regfile_wb_pipe dut (
    .clock         (clock),
    .reset         (reset),
    .i_wr_issue    (wr_issue),
    .i_wr_addr     (wr_addr),
    .i_wr_data     (wr_data),
    .i_rs_addr     (rs_addr),
    .o_rd_data     (rd_data),
    .o_rs_busy     (rs_busy),
    .o_commit_vld  (commit_vld),
    .o_commit_addr (commit_addr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    // 1. Reset with traffic on every input
    reset = 1'b1; wr_issue = 1'b1; wr_addr = 5'd3; wr_data = 32'hAAAA_AAAA;
    rs_addr = {5'd3, 5'd3};
    step();
    step();
    check("rst_rd0",    rd_data[31:0],  32'h0);
    check("rst_rd1",    rd_data[63:32], 32'h0);
    check("rst_busy",   {30'd0, rs_busy}, 32'h0);
    check("rst_commit", {31'd0, commit_vld}, 32'h0);
    reset = 1'b0; wr_issue = 1'b0;
    step();
    step();
    step();
    check("rst_x3_empty", rd_data[31:0], 32'h0);
    check("rst_no_commit", {31'd0, commit_vld}, 32'h0);

    // 2. Write x5, data at the commit cycle, then read back from the array
    wr_issue = 1'b1; wr_addr = 5'd5; rs_addr = {5'd0, 5'd5};
    step();                               // edge n
    wr_issue = 1'b0; wr_addr = 5'd12;
    check("x5_busy", {30'd0, rs_busy}, 32'h1);
    step();                               // edge n+1
    wr_data = 32'hDEAD_BEEF;
    check("x5_commit_vld",  {31'd0, commit_vld}, 32'h1);
    check("x5_commit_addr", {27'd0, commit_addr}, 32'd5);
    step();                               // edge n+2: commit
    wr_data = 32'h0;
    check("x5_busy_clear", {30'd0, rs_busy}, 32'h0);
    step();
    check("x5_read", rd_data[31:0], 32'hDEAD_BEEF);

    // 3. Bypass on both ports reading x5 in its commit cycle
    wr_issue = 1'b1; wr_addr = 5'd5;
    step();
    wr_issue = 1'b0;
    rs_addr = {5'd5, 5'd5};
    step();
    wr_data = 32'h1234_5678;
    step();
    wr_data = 32'h0;
    check("byp_p0", rd_data[31:0],  32'h1234_5678);
    check("byp_p1", rd_data[63:32], 32'h1234_5678);
    check("idle_addr_not_busy", {30'd0, rs_busy}, 32'h0);

    // 4. Writes to x0 never land and never mark busy
    wr_issue = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    rs_addr = {5'd0, 5'd0};
    check("x0_busy_c0", {30'd0, rs_busy}, 32'h0);
    step();
    wr_issue = 1'b0;
    check("x0_busy_c1", {30'd0, rs_busy}, 32'h0);
    step();
    check("x0_commit_vld", {31'd0, commit_vld}, 32'h1);
    check("x0_busy_c2", {30'd0, rs_busy}, 32'h0);
    step();
    check("x0_read", rd_data[31:0], 32'h0);
    check("x0_busy_c3", {30'd0, rs_busy}, 32'h0);

    // 5. Two back-to-back issues to x7
    wr_data = 32'h0; rs_addr = {5'd0, 5'd7};
    wr_issue = 1'b1; wr_addr = 5'd7;
    check("x7_busy_before", {30'd0, rs_busy}, 32'h0);
    step();                               // first issue captured, cnt=1
    check("x7_busy_1", {30'd0, rs_busy}, 32'h1);
    step();                               // second issue captured, cnt=2
    wr_issue = 1'b0;
    check("x7_busy_2", {30'd0, rs_busy}, 32'h1);
    check("x7_rd_before", rd_data[31:0], 32'h0);
    wr_data = 32'h1111_1111;              // first commit
    step();                               // cnt=1
    check("x7_busy_3", {30'd0, rs_busy}, 32'h1);
    check("x7_rd_first", rd_data[31:0], 32'h1111_1111);
    wr_data = 32'h2222_2222;              // second commit
    step();                               // cnt=0
    wr_data = 32'h0;
    check("x7_busy_done", {30'd0, rs_busy}, 32'h0);
    check("x7_rd_byp", rd_data[31:0], 32'h2222_2222);
    step();
    check("x7_rd_final", rd_data[31:0], 32'h2222_2222);

    // wr_addr is ignored while wr_issue=0
    wr_issue = 1'b0; wr_addr = 5'd12; rs_addr = {5'd12, 5'd0};
    step();
    check("noissue_busy", {30'd0, rs_busy}, 32'h0);

    // 6. Reset while x9 is in flight
    wr_issue = 1'b1; wr_addr = 5'd9; rs_addr = {5'd7, 5'd9};
    step();
    wr_issue = 1'b0;
    check("x9_busy_pre", {30'd0, rs_busy}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    wr_data = 32'h9999_9999;
    check("x9_busy_rst",   {30'd0, rs_busy}, 32'h0);
    check("x9_commit_rst", {31'd0, commit_vld}, 32'h0);
    step();
    check("x9_no_commit_1", {31'd0, commit_vld}, 32'h0);
    step();
    check("x9_no_commit_2", {31'd0, commit_vld}, 32'h0);
    check("x9_read",     rd_data[31:0],  32'h0);
    check("x7_cleared",  rd_data[63:32], 32'h0);
    check("x9_busy_end", {30'd0, rs_busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
